// File: rtl/px_arb_pkg.sv
// Shared constants and state encoding for the pixel-write arbiter.
package px_arb_pkg;

    localparam int FB_W    = 160;
    localparam int FB_H    = 128;
    localparam int FB_SIZE = FB_W * FB_H;

    localparam logic [2:0] COLOR_FONDO = 3'b001;
    localparam logic [2:0] COLOR_BARRA = 3'b010;
    localparam logic [2:0] COLOR_BOLA  = 3'b111;
    localparam logic [2:0] COLOR_ROJO  = 3'b100;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/px_fifo.sv
// Small synchronous FIFO with a separate occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module px_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/px_write_arbiter.sv
// Merges the paddle (ch0) and ball (ch1) pixel-write channels onto the
// frame-buffer write port through per-channel FIFOs and a round-robin grant.
// Optional power-up clear sweep controlled by macro PX_ARB_CLEAR_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping CLEAR_COLOR over every pixel; FIFOs fill, no drain
// ST_RUN   | draining FIFOs one pixel per cycle, round-robin on ties
module px_write_arbiter
    import px_arb_pkg::*;
#(
    parameter int             AW          = 15,
    parameter int             DW          = 3,
    parameter int             FIFO_DEPTH  = 8,
    parameter logic [DW-1:0]  CLEAR_COLOR = 3'b001
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] in0_addr,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_wr,
    input  logic [AW-1:0] in1_addr,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr,
    output logic          ovf0,
    output logic          ovf1,
    output logic          busy
);

    localparam int            EW         = AW + DW;
    localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(FB_SIZE);

    logic [EW-1:0] ch_entry  [2];
    logic [1:0]    ch_wr;
    logic [1:0]    candidate;
    logic [1:0]    drop_full;
    logic [1:0]    f_push;
    logic [1:0]    f_pop;
    logic [1:0]    f_full;
    logic [1:0]    f_empty;
    logic [EW-1:0] f_rdata   [2];
    logic [CW-1:0] f_count   [2];
    logic [1:0]    dup_valid;
    logic [EW-1:0] dup_entry [2];
    logic [1:0]    ovf;
    state_t        state;
    state_t        state_next;
    logic          rr_last;
    logic          tie;
    logic [AW-1:0] sweep_addr;

    assign ch_entry[0] = {in0_addr, in0_data};
    assign ch_entry[1] = {in1_addr, in1_data};
    assign ch_wr       = {in1_wr, in0_wr};
    assign ovf0        = ovf[0];
    assign ovf1        = ovf[1];
    assign busy        = (state == ST_CLEAR) || (f_count[0] != '0) ||
                         (f_count[1] != '0) || mem_wr;

`ifdef PX_ARB_CLEAR_EN
    localparam state_t        RESET_STATE = ST_CLEAR;
    localparam logic [AW-1:0] SWEEP_LAST  = AW'(FB_SIZE - 1);

    logic [AW-1:0] sweep_cnt;

    assign sweep_addr = sweep_cnt;

    // Sweep address counter, stops at the last pixel (no wrap).
    always_ff @(posedge clk) begin
        if (!rst) begin
            sweep_cnt <= '0;
        end else if (state == ST_CLEAR && sweep_cnt != SWEEP_LAST) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end
`else
    localparam state_t RESET_STATE = ST_RUN;

    // Without the sweep the CLEAR state is never entered.
    assign sweep_addr = '0;
`endif

    // Accept filter: range check, then dedup, then full-and-not-popped drop.
    always_comb begin
        candidate = '0;
        f_push    = '0;
        drop_full = '0;
        for (int i = 0; i < 2; i++) begin
            candidate[i] = ch_wr[i] && (ch_entry[i][EW-1:DW] < ADDR_LIMIT) &&
                           !(dup_valid[i] && (dup_entry[i] == ch_entry[i]));
            f_push[i]    = candidate[i] && (!f_full[i] || f_pop[i]);
            drop_full[i] = candidate[i] && f_full[i] && !f_pop[i];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        px_fifo #(
            .W     (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (f_push[i]),
            .pop   (f_pop[i]),
            .wdata (ch_entry[i]),
            .rdata (f_rdata[i]),
            .full  (f_full[i]),
            .empty (f_empty[i]),
            .count (f_count[i])
        );
    end

    // Last-accepted entry per channel for dedup, plus sticky overflow flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dup_valid <= '0;
            ovf       <= '0;
            for (int i = 0; i < 2; i++) begin
                dup_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (f_push[i]) begin
                    dup_valid[i] <= 1'b1;
                    dup_entry[i] <= ch_entry[i];
                end
                if (drop_full[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pop grant; on a tie the channel not granted last wins.
    always_comb begin
        state_next = state;
        f_pop      = '0;
        tie        = 1'b0;
        case (state)
            ST_CLEAR: begin
`ifdef PX_ARB_CLEAR_EN
                if (sweep_cnt == SWEEP_LAST) begin
                    state_next = ST_RUN;
                end
`else
                state_next = ST_RUN;
`endif
            end
            default: begin
                if (!f_empty[0] && !f_empty[1]) begin
                    tie = 1'b1;
                    if (rr_last) begin
                        f_pop[0] = 1'b1;
                    end else begin
                        f_pop[1] = 1'b1;
                    end
                end else if (!f_empty[0]) begin
                    f_pop[0] = 1'b1;
                end else if (!f_empty[1]) begin
                    f_pop[1] = 1'b1;
                end
            end
        endcase
    end

    // Round-robin pointer: remembers which channel won the last tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_last <= 1'b1;
        end else if (tie) begin
            rr_last <= f_pop[1];
        end
    end

    // Registered frame-buffer write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (state == ST_CLEAR) begin
            mem_wr   <= 1'b1;
            mem_addr <= sweep_addr;
            mem_data <= CLEAR_COLOR;
        end else if (f_pop[0]) begin
            mem_wr   <= 1'b1;
            mem_addr <= f_rdata[0][EW-1:DW];
            mem_data <= f_rdata[0][DW-1:0];
        end else if (f_pop[1]) begin
            mem_wr   <= 1'b1;
            mem_addr <= f_rdata[1][EW-1:DW];
            mem_data <= f_rdata[1][DW-1:0];
        end else begin
            mem_wr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_px_write_arbiter.sv
// Bench for px_write_arbiter: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model.
// Clear-sweep scenarios are included when PX_ARB_CLEAR_EN is defined.
module tb_px_write_arbiter;

    localparam int AW      = 15;
    localparam int DW      = 3;
    localparam int EW      = AW + DW;
    localparam int DEPTH   = 8;
    localparam int FB_SIZE = 20480;
    localparam logic [DW-1:0] CLEAR_C = 3'b001;
`ifdef PX_ARB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] in0_addr, in1_addr;
    logic [DW-1:0] in0_data, in1_data;
    logic          in0_wr, in1_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wr, ovf0, ovf1, busy;

    px_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .in0_addr (in0_addr),
        .in0_data (in0_data),
        .in0_wr   (in0_wr),
        .in1_addr (in1_addr),
        .in1_data (in1_data),
        .in1_wr   (in1_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr   (mem_wr),
        .ovf0     (ovf0),
        .ovf1     (ovf1),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    bit            m_dv    [2];
    logic [EW-1:0] m_dlast [2];
    bit            m_ovf   [2];
    int            m_ptr;
    bit            m_clear;
    int            m_sweep;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_busy;

    logic [EW-1:0] wlog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_dv[0] = 0; m_dv[1] = 0;
        m_dlast[0] = '0; m_dlast[1] = '0;
        m_ovf[0] = 0; m_ovf[1] = 0;
        m_ptr    = 1;
        m_clear  = CLR;
        m_sweep  = 0;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic model_push(input int ch, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic w);
        logic [EW-1:0] e;
        int sz;
        e = {a, d};
        if (!w || int'(a) >= FB_SIZE) return;
        if (m_dv[ch] && m_dlast[ch] == e) return;
        sz = (ch == 0) ? q0.size() : q1.size();
        if (sz < DEPTH) begin
            if (ch == 0) q0.push_back(e); else q1.push_back(e);
            m_dv[ch]    = 1;
            m_dlast[ch] = e;
        end else begin
            m_ovf[ch] = 1;
        end
    endtask

    // One clock of the reference model, using the inputs about to be sampled.
    task automatic model_edge();
        int sel;
        logic [EW-1:0] e;
        if (!rst) begin
            model_reset();
        end else begin
            sel = -1;
            if (m_clear) begin
                exp_wr   = 1'b1;
                exp_addr = AW'(m_sweep);
                exp_data = CLEAR_C;
                if (m_sweep == FB_SIZE - 1) m_clear = 0;
                else m_sweep++;
            end else begin
                if (q0.size() > 0 && q1.size() > 0) begin
                    sel   = (m_ptr == 1) ? 0 : 1;
                    m_ptr = sel;
                end else if (q0.size() > 0) begin
                    sel = 0;
                end else if (q1.size() > 0) begin
                    sel = 1;
                end
                if (sel == 0) e = q0.pop_front();
                else if (sel == 1) e = q1.pop_front();
                if (sel >= 0) begin
                    exp_wr = 1'b1;
                    {exp_addr, exp_data} = e;
                end else begin
                    exp_wr = 1'b0;
                end
            end
            model_push(0, in0_addr, in0_data, in0_wr);
            model_push(1, in1_addr, in1_data, in1_wr);
        end
        exp_busy = m_clear || (q0.size() > 0) || (q1.size() > 0) || exp_wr;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("mem_wr",   32'(mem_wr),   32'(exp_wr));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("mem_data", 32'(mem_data), 32'(exp_data));
        chk("ovf0",     32'(ovf0),     32'(m_ovf[0]));
        chk("ovf1",     32'(ovf1),     32'(m_ovf[1]));
        chk("busy",     32'(busy),     32'(exp_busy));
        if (mem_wr) wlog.push_back({mem_addr, mem_data});
    endtask

    task automatic idle();
        in0_wr = 1'b0;
        in1_wr = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && busy; k++) tick();
        chk("drain_done", 32'(busy), 32'd0);
        tick();
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 6) return AW'(300 + $urandom_range(0, 5));
        if (r < 7) return AW'(FB_SIZE + $urandom_range(0, 32767 - FB_SIZE));
        return AW'($urandom_range(0, FB_SIZE - 1));
    endfunction

    initial begin
        int bad;
        bit seen [int];

        rst = 1'b0;
        in0_addr = '0; in0_data = '0; in0_wr = 1'b0;
        in1_addr = '0; in1_data = '0; in1_wr = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_mem_wr",   32'(mem_wr),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ovf0",     32'(ovf0),     32'd0);
        chk("rst_ovf1",     32'(ovf1),     32'd0);
        chk("rst_busy",     32'(busy),     32'(CLR));
        rst = 1'b1;

`ifdef PX_ARB_CLEAR_EN
        // sweep interrupted at address 5000 restarts from 0
        for (int k = 0; k < 6000 && !(mem_wr && mem_addr == AW'(5000)); k++) tick();
        chk("sweep_reach_5000", 32'(mem_addr), 32'd5000);
        rst = 1'b0;
        tick();
        chk("sweep_rst_wr", 32'(mem_wr), 32'd0);
        wlog.delete();
        rst = 1'b1;
        tick();
        chk("sweep_restart_wr",   32'(mem_wr),   32'd1);
        chk("sweep_restart_addr", 32'(mem_addr), 32'd0);
        for (int k = 0; k < 10; k++) tick();
        in1_addr = AW'(777); in1_data = 3'd7; in1_wr = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 21000 && m_clear; k++) tick();
        tick(); tick(); tick();
        bad = 0;
        for (int i = 0; i < FB_SIZE && i < wlog.size(); i++)
            if (wlog[i] !== {AW'(i), CLEAR_C}) bad++;
        chk("sweep_seq_bad", 32'(bad), 32'd0);
        if (wlog.size() > FB_SIZE)
            chk("sweep_then_ch1", 32'(wlog[FB_SIZE]), 32'({AW'(777), 3'd7}));
        else
            chk("sweep_len", 32'(wlog.size()), 32'(FB_SIZE + 1));
        chk("sweep_busy_end", 32'(busy), 32'd0);
`endif

        // single write latency
        wlog.delete();
        in0_addr = AW'(12880); in0_data = 3'b010; in0_wr = 1'b1;
        tick();
        idle();
        chk("lat_edge_n", 32'(mem_wr), 32'd0);
        tick();
        chk("lat_wr",   32'(mem_wr),   32'd1);
        chk("lat_addr", 32'(mem_addr), 32'd12880);
        chk("lat_data", 32'(mem_data), 32'd2);
        tick();
        chk("lat_pulse", 32'(mem_wr), 32'd0);
        chk("lat_busy",  32'(busy),   32'd0);

        // both channels for 4 cycles: alternate, ch0 first
        wlog.delete();
        for (int k = 0; k < 4; k++) begin
            in0_addr = AW'(100 + k); in0_data = 3'b010; in0_wr = 1'b1;
            in1_addr = AW'(200 + k); in1_data = 3'b111; in1_wr = 1'b1;
            tick();
        end
        idle();
        drain();
        chk("alt_count", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < 8 && k < wlog.size(); k++)
            chk("alt_order", 32'(wlog[k]),
                (k % 2 == 0) ? 32'({AW'(100 + k / 2), 3'b010}) : 32'({AW'(200 + k / 2), 3'b111}));
        chk("alt_ovf0", 32'(ovf0), 32'd0);
        chk("alt_ovf1", 32'(ovf1), 32'd0);

        // held stable write produces one memory write
        wlog.delete();
        in0_addr = AW'(10320); in0_data = 3'b100; in0_wr = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        idle();
        drain();
        chk("hold_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("hold_entry", 32'(wlog[0]), 32'({AW'(10320), 3'b100}));

        // out-of-range address is ignored
        wlog.delete();
        in0_addr = AW'(FB_SIZE); in0_data = 3'b111; in0_wr = 1'b1;
        tick();
        in0_addr = AW'(32767);
        tick();
        idle();
        tick(); tick();
        chk("oor_count", 32'(wlog.size()), 32'd0);
        chk("oor_ovf0",  32'(ovf0),        32'd0);

        // both channels streaming 24 cycles overflow both FIFOs
        wlog.delete();
        for (int k = 0; k < 24; k++) begin
            in0_addr = AW'(k);        in0_data = 3'b010; in0_wr = 1'b1;
            in1_addr = AW'(1000 + k); in1_data = 3'b111; in1_wr = 1'b1;
            tick();
            if (k == 19) begin
                chk("stream_ovf0_by20", 32'(ovf0), 32'd1);
                chk("stream_ovf1_by20", 32'(ovf1), 32'd1);
            end
        end
        idle();
        drain();
        chk("stream_total", 32'(wlog.size()), 32'(2 * DEPTH + 23));
        bad = 0;
        foreach (wlog[i]) begin
            if (seen.exists(int'(wlog[i]))) bad++;
            seen[int'(wlog[i])] = 1;
        end
        chk("stream_dups", 32'(bad), 32'd0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                in0_wr   = ($urandom_range(0, 9) < 6);
                in0_addr = pick_addr();
                in0_data = DW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) begin
                in1_wr   = ($urandom_range(0, 9) < 6);
                in1_addr = pick_addr();
                in1_data = DW'($urandom_range(0, 7));
            end
            rst = !(!CLR && $urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b1;
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
